// File: rtl/lut_interp_reader_if.sv
// Request, result and table-RAM signals of the LUT interpolating reader.
// The controller connects through the slave modport.
interface lut_interp_reader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 6,
  parameter int TABLE_BITS = 1
);
  logic                             in_valid;
  logic                             in_ready;
  logic [TABLE_BITS-1:0]            in_table;
  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] in_phase;
  logic [TABLE_BITS+ADDR_WIDTH-1:0] mem_addr;
  logic                             mem_rd_en;
  logic [DATA_WIDTH-1:0]            mem_rd_data;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             busy;

  modport slave (
    input  in_valid, in_table, in_phase, mem_rd_data, out_ready,
    output in_ready, mem_addr, mem_rd_en, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_table, in_phase, mem_rd_data, out_ready,
    input  in_ready, mem_addr, mem_rd_en, out_valid, out_data, busy
  );
endinterface

// File: rtl/lut_interp_reader.sv
// Fetches two adjacent table entries for a fractional phase and returns
// the linearly interpolated sample; all outputs are registered.
module lut_interp_reader #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_WIDTH  = 6,
  parameter int TABLE_BITS  = 1,
  parameter int RD_LATENCY  = 1,
  parameter int SIGNED_DATA = 1,
  parameter int WRAP        = 1
) (
  input  logic               clk,
  input  logic               rst,
  lut_interp_reader_if.slave bus
);
  localparam int PHASE_W = ADDR_WIDTH + FRAC_WIDTH;
  localparam int WIDE_W  = DATA_WIDTH + FRAC_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, RD0, RD1, WAIT, CALC, OUT} state_t;

  state_t                  state;
  logic [TABLE_BITS-1:0]   table_q;
  logic [ADDR_WIDTH-1:0]   index_q;
  logic [ADDR_WIDTH-1:0]   index_next;
  logic [FRAC_WIDTH-1:0]   frac_q;
  logic [DATA_WIDTH-1:0]   a_q;

  logic signed [DATA_WIDTH:0]   a_ext, b_ext, diff;
  logic signed [WIDE_W-1:0]     a_wide, diff_wide, frac_wide, prod, y_wide;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    index_next = index_q + 1'b1;
    if (WRAP == 0 && index_q == '1) index_next = index_q;
  end

  // b is never stored: it is consumed straight off the RAM bus in CALC,
  // which is what lets a result appear RD_LATENCY+3 cycles after accept.
  assign a_ext = (SIGNED_DATA != 0) ? {a_q[DATA_WIDTH-1], a_q} : {1'b0, a_q};
  assign b_ext = (SIGNED_DATA != 0) ? {bus.mem_rd_data[DATA_WIDTH-1], bus.mem_rd_data}
                                    : {1'b0, bus.mem_rd_data};
  assign diff      = b_ext - a_ext;
  assign diff_wide = {{(FRAC_WIDTH+1){diff[DATA_WIDTH]}}, diff};
  assign a_wide    = {{(FRAC_WIDTH+1){a_ext[DATA_WIDTH]}}, a_ext};
  assign frac_wide = {{(DATA_WIDTH+2){1'b0}}, frac_q};
  assign prod      = diff_wide * frac_wide;
  assign y_wide    = a_wide + (prod >>> FRAC_WIDTH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.busy      <= 1'b0;
      table_q       <= '0;
      index_q       <= '0;
      frac_q        <= '0;
      a_q           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            table_q       <= bus.in_table;
            index_q       <= bus.in_phase[PHASE_W-1:FRAC_WIDTH];
            frac_q        <= bus.in_phase[FRAC_WIDTH-1:0];
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= {bus.in_table, bus.in_phase[PHASE_W-1:FRAC_WIDTH]};
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= RD0;
          end else begin
            bus.in_ready  <= 1'b1;
          end
        end
        RD0: begin
          bus.mem_addr <= {table_q, index_next};
          state        <= RD1;
        end
        RD1: begin
          bus.mem_rd_en <= 1'b0;
          // With a one-cycle RAM, a is already on the bus and WAIT is skipped.
          if (RD_LATENCY == 1) begin
            a_q   <= bus.mem_rd_data;
            state <= CALC;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          a_q   <= bus.mem_rd_data;
          state <= CALC;
        end
        CALC: begin
          bus.out_data  <= y_wide[DATA_WIDTH-1:0];
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lut_interp_reader.sv
// Directed bench: three controllers (wrap/L1, clamp/L1, wrap/L2) share one
// behavioural table RAM; each sees its own read-latency pipeline.
module tb_lut_interp_reader;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [15:0] mem [0:2047];

  logic        in_valid_v  [3];
  logic        in_table_v  [3];
  logic [15:0] in_phase_v  [3];
  logic        out_ready_v [3];
  logic        in_ready_v  [3];
  logic [10:0] mem_addr_v  [3];
  logic        mem_rd_en_v [3];
  logic        out_valid_v [3];
  logic [15:0] out_data_v  [3];
  logic        busy_v      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 2 : 1;
    localparam int WRP = (g == 1) ? 0 : 1;

    lut_interp_reader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .FRAC_WIDTH(6), .TABLE_BITS(1)) bus ();

    lut_interp_reader #(
      .ADDR_WIDTH(10), .DATA_WIDTH(16), .FRAC_WIDTH(6), .TABLE_BITS(1),
      .RD_LATENCY(LAT), .SIGNED_DATA(1), .WRAP(WRP)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [15:0] q1, q2;
    always @(posedge clk) begin
      if (bus.mem_rd_en) q1 <= mem[bus.mem_addr];
      q2 <= q1;
    end
    assign bus.mem_rd_data = (LAT == 2) ? q2 : q1;

    assign bus.in_valid   = in_valid_v[g];
    assign bus.in_table   = in_table_v[g];
    assign bus.in_phase   = in_phase_v[g];
    assign bus.out_ready  = out_ready_v[g];
    assign in_ready_v[g]  = bus.in_ready;
    assign mem_addr_v[g]  = bus.mem_addr;
    assign mem_rd_en_v[g] = bus.mem_rd_en;
    assign out_valid_v[g] = bus.out_valid;
    assign out_data_v[g]  = bus.out_data;
    assign busy_v[g]      = bus.busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction with out_ready already high; returns the two
  // read addresses, the result and cycles from accept to out_valid.
  task automatic request(input int s, input logic t, input logic [15:0] ph,
                         output logic [15:0] d, output int lat,
                         output logic [10:0] a0, output logic [10:0] a1);
    int k;
    k = 0;
    while (!in_ready_v[s] && k < 20) begin tick(); k++; end
    in_table_v[s] = t;
    in_phase_v[s] = ph;
    in_valid_v[s] = 1'b1;
    tick();
    in_valid_v[s] = 1'b0;
    a0 = mem_addr_v[s];
    tick();
    a1 = mem_addr_v[s];
    lat = 2;
    while (!out_valid_v[s] && lat < 12) begin tick(); lat++; end
    d = out_data_v[s];
    tick();
  endtask

  logic [15:0] d;
  logic [10:0] a0, a1;
  int          lat;
  logic        seen;

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      in_valid_v[s] = 1'b0; in_table_v[s] = 1'b0; in_phase_v[s] = '0; out_ready_v[s] = 1'b1;
    end
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[11'h005] = 16'h0100; mem[11'h006] = 16'h0200;
    mem[11'h407] = 16'h0010; mem[11'h408] = 16'hFFF0;
    mem[11'h3FF] = 16'h1000; mem[11'h000] = 16'h3000;
    mem[11'h464] = 16'h1234;

    // Reset state, with a request presented during reset that must be ignored
    in_valid_v[0] = 1'b1;
    tick(); tick();
    check("rst_in_ready",  in_ready_v[0],  0);
    check("rst_out_valid", out_valid_v[0], 0);
    check("rst_out_data",  out_data_v[0],  0);
    check("rst_mem_rd_en", mem_rd_en_v[0], 0);
    check("rst_mem_addr",  mem_addr_v[0],  0);
    check("rst_busy",      busy_v[0],      0);
    rst = 1'b0;
    in_valid_v[0] = 1'b0;
    check("rel_in_ready0", in_ready_v[0], 0);
    tick();
    check("rel_in_ready1", in_ready_v[0], 1);
    check("rel_busy",      busy_v[0],     0);

    // Basic interpolation, cycle by cycle: i=5 f=32 -> 0x0180
    out_ready_v[0] = 1'b0;
    in_table_v[0] = 1'b0; in_phase_v[0] = 16'h0160; in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    check("b_rd0_en",    mem_rd_en_v[0], 1);
    check("b_rd0_addr",  mem_addr_v[0],  11'h005);
    check("b_rd0_ready", in_ready_v[0],  0);
    check("b_rd0_busy",  busy_v[0],      1);
    tick();
    check("b_rd1_en",    mem_rd_en_v[0], 1);
    check("b_rd1_addr",  mem_addr_v[0],  11'h006);
    tick();
    check("b_t3_en",     mem_rd_en_v[0], 0);
    check("b_t3_addr",   mem_addr_v[0],  11'h006);
    check("b_t3_valid",  out_valid_v[0], 0);
    tick();
    check("b_t4_valid",  out_valid_v[0], 1);
    check("b_t4_data",   out_data_v[0],  16'h0180);
    out_ready_v[0] = 1'b1;
    tick();
    check("b_hs_valid",  out_valid_v[0], 0);
    check("b_hs_ready",  in_ready_v[0],  1);
    check("b_hs_busy",   busy_v[0],      0);

    // Signed downward slope: table1, i=7, f=16 -> 0x0008
    request(0, 1'b1, 16'h01D0, d, lat, a0, a1);
    check("slope_a0",   a0,  11'h407);
    check("slope_a1",   a1,  11'h408);
    check("slope_data", d,   16'h0008);
    check("slope_lat",  lat, 4);

    // Table end: i=1023, f=32 under wrap and clamp
    request(0, 1'b0, 16'hFFE0, d, lat, a0, a1);
    check("wrap_a0",   a0, 11'h3FF);
    check("wrap_a1",   a1, 11'h000);
    check("wrap_data", d,  16'h2000);
    request(1, 1'b0, 16'hFFE0, d, lat, a0, a1);
    check("clamp_a1",   a1, 11'h3FF);
    check("clamp_data", d,  16'h1000);
    check("clamp_lat",  lat, 4);

    // Latency 2 with 5 cycles of backpressure and a queued request
    out_ready_v[2] = 1'b0;
    in_table_v[2] = 1'b0; in_phase_v[2] = 16'h0160; in_valid_v[2] = 1'b1;
    lat = 0;
    while (!in_ready_v[2] && lat < 20) begin tick(); lat++; end
    tick();
    in_valid_v[2] = 1'b0;
    lat = 1;
    while (!out_valid_v[2] && lat < 12) begin tick(); lat++; end
    check("bp_lat", lat, 5);
    in_table_v[2] = 1'b1; in_phase_v[2] = 16'h01D0; in_valid_v[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", out_valid_v[2], 1);
      check("bp_hold_data",  out_data_v[2],  16'h0180);
      check("bp_hold_ready", in_ready_v[2],  0);
      tick();
    end
    out_ready_v[2] = 1'b1;
    check("bp_last_valid", out_valid_v[2], 1);
    tick();
    check("bp_idle_ready", in_ready_v[2], 1);
    check("bp_idle_busy",  busy_v[2],     0);
    tick();
    in_valid_v[2] = 1'b0;
    check("bp_acc_busy", busy_v[2],     1);
    check("bp_acc_addr", mem_addr_v[2], 11'h407);
    lat = 1;
    while (!out_valid_v[2] && lat < 12) begin tick(); lat++; end
    check("bp2_lat",  lat,           5);
    check("bp2_data", out_data_v[2], 16'h0008);
    tick();

    // Reset while waiting for read data, then a clean f=0 request
    in_table_v[2] = 1'b0; in_phase_v[2] = 16'h0160; in_valid_v[2] = 1'b1;
    tick();
    in_valid_v[2] = 1'b0;
    tick(); tick();
    check("mid_wait_en", mem_rd_en_v[2], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_valid", out_valid_v[2], 0);
    check("mid_en",    mem_rd_en_v[2], 0);
    check("mid_busy",  busy_v[2],      0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | out_valid_v[2];
    end
    check("mid_no_stale", seen, 0);
    request(2, 1'b1, 16'h1900, d, lat, a0, a1);
    check("fresh_a0",   a0,  11'h464);
    check("fresh_data", d,   16'h1234);
    check("fresh_lat",  lat, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lut_interp_reader.md
# lut_interp_reader

Read controller for the voice-effect lookup tables: accepts a fixed-point phase (integer index plus fraction) and a table select, fetches two adjacent entries from an external single-port table RAM, and returns the linearly interpolated sample. It generalises single-table, integer-address lookup to several tables, fractional addressing, selectable RAM read latency, and wrap or clamp at the table end. It sits between the pitch/formant phase generators and the table RAM that holds the per-voice curves.

## Interface
- ADDR_WIDTH, 10, entries per table = 2^ADDR_WIDTH
- DATA_WIDTH, 16, table entry and output width
- FRAC_WIDTH, 6, fractional phase bits (≥1)
- TABLE_BITS, 1, number of tables = 2^TABLE_BITS
- RD_LATENCY, 1, RAM read latency in cycles: 1 for an unregistered RAM output, 2 for a registered one; other values are illegal
- SIGNED_DATA, 1, 1 = entries are two's complement, 0 = unsigned
- WRAP, 1, 1 = the entry after the last one is entry 0 of the same table; 0 = clamp to the last entry
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- in_table  in  TABLE_BITS  table select
- in_phase  in  ADDR_WIDTH+FRAC_WIDTH  [MSBs] index, [FRAC_WIDTH-1:0] fraction
- mem_addr  out  TABLE_BITS+ADDR_WIDTH  RAM address, {table, index}
- mem_rd_en  out  1  RAM read strobe
- mem_rd_data  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after the strobe
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DATA_WIDTH  interpolated sample
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE → RD0 → RD1 → WAIT → CALC → OUT → IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, latch the table, index i and fraction f, then go to RD0.
- RD0 (one cycle): mem_rd_en=1, mem_addr={table,i}.
- RD1 (one cycle): mem_rd_en=1, mem_addr={table,i1}.
  - i1 = i+1 modulo 2^ADDR_WIDTH when WRAP=1.
  - i1 = min(i+1, 2^ADDR_WIDTH−1) when WRAP=0.
- WAIT: mem_rd_en=0. Capture a from mem_rd_data in the cycle RD_LATENCY after RD0, and b in the cycle RD_LATENCY after RD1. Leave WAIT in the cycle b is captured.
- CALC (one cycle), registered into out_data:
  - a and b are extended to DATA_WIDTH+1 bits: sign-extended when SIGNED_DATA=1, zero-extended when SIGNED_DATA=0.
  - d = b − a, signed.
  - p = d × {0,f}, signed.
  - y = a + (p >>> FRAC_WIDTH), using an arithmetic shift (floor).
  - out_data = y[DATA_WIDTH-1:0]. No saturation is needed because y always lies between a and b.
  - f=0 gives y=a exactly.
- OUT: out_valid=1 and out_data is held stable until out_valid&out_ready, then go to IDLE.
- in_valid while not in IDLE is ignored. The requester must hold its request.
- mem_addr holds its last value when mem_rd_en=0.

## Timing
- Reset: in_ready=0, out_valid=0, out_data=0, mem_rd_en=0, mem_addr=0, busy=0, state IDLE. in_ready goes to 1 in the first cycle after rst is released.
- Accept at cycle T:
  - RD0 at T+1.
  - RD1 at T+2.
  - a valid at T+1+L and b valid at T+2+L, where L = RD_LATENCY.
  - out_valid first high at T+3+L, i.e. T+4 for L=1 and T+5 for L=2.
- in_ready goes low at T+1. It returns high in the cycle after the out_valid&out_ready handshake.
- Back-to-back throughput with out_ready tied high: one result per 4+L cycles.
- rst asserted in any state: the next cycle is IDLE with the reset values above. Read data still in flight is discarded, and no out_valid is produced for the aborted request.
- Simultaneous rst and in_valid: reset wins and the request is not accepted.

## Test plan
- Basic interpolation (RD_LATENCY=1, SIGNED_DATA=1): table0[5]=0x0100, table0[6]=0x0200, in_phase=0x0160 (i=5, f=32) → out_data=0x0180. out_valid first high 4 cycles after accept. mem_addr sequence is 0x005 then 0x006.
- Signed downward slope: table1[7]=0x0010, table1[8]=0xFFF0, in_table=1, i=7, f=16 → out_data=0x0008.
- Wrap and clamp: table0[1023]=0x1000, table0[0]=0x3000, i=1023, f=32.
  - WRAP=1 → second address 0x000, out_data=0x2000.
  - WRAP=0 → second address 0x3FF, out_data=0x1000.
- Backpressure and latency: RD_LATENCY=2, out_ready low for 5 cycles after out_valid rises.
  - out_valid rises 5 cycles after accept.
  - out_data stays stable and in_ready stays 0 while out_ready is low.
  - A new in_valid held during this time is accepted in the cycle after the handshake.
- Reset mid-operation: assert rst for one cycle during WAIT.
  - Next cycle: out_valid=0, mem_rd_en=0, busy=0.
  - No stale result appears afterwards.
  - A fresh request with f=0 returns exactly table[i].
